// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt capture / controller pair.
package irq_pkg;

  localparam int N_SRC_DEF       = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int SRC_IDX_W       = $clog2(N_SRC_DEF);

  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  function automatic logic [N_SRC_DEF-1:0] src_onehot(input src_idx_t idx);
    logic [N_SRC_DEF-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/interrupt_request_capture_if.sv
// Source-side and controller-side signals of the interrupt request capture block.
interface interrupt_request_capture_if
  import irq_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
);

  logic [N_SRC-1:0] irq_in;
  logic [N_SRC-1:0] cfg_edge;
  logic [N_SRC-1:0] int_fin;
  logic             sw_we;
  logic [N_SRC-1:0] sw_set;
  logic [N_SRC-1:0] ovr_clr;
  logic [N_SRC-1:0] int_req;
  logic [N_SRC-1:0] overrun;

  modport master (
    output irq_in, cfg_edge, int_fin, sw_we, sw_set, ovr_clr,
    input  int_req, overrun
  );

  modport slave (
    input  irq_in, cfg_edge, int_fin, sw_we, sw_set, ovr_clr,
    output int_req, overrun
  );

endinterface

// File: rtl/irq_sync_bit.sv
// Single-bit multi-flop synchronizer for one asynchronous interrupt line.
module irq_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/interrupt_request_capture.sv
// Synchronizes raw interrupt lines and keeps a per-source pending vector with
// edge/level capture, software set and sticky overrun flags.
module interrupt_request_capture
  import irq_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic                        clk,
  input logic                        rst_n,
  interrupt_request_capture_if.slave bus
);

  logic [N_SRC-1:0] w_s;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_ovr;
  logic [N_SRC-1:0] r_cfg_edge;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_sw;
  logic [N_SRC-1:0] w_toggle;
  logic [N_SRC-1:0] w_pend_edge;
  logic [N_SRC-1:0] w_pend_lvl;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_ovr_set;
  logic [N_SRC-1:0] w_ovr_nxt;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_sync
    irq_sync_bit #(
      .STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.irq_in[gi]),
      .o_q   (w_s[gi])
    );
  end

  // A set landing with int_fin keeps the source pending; a mode change wipes it.
  always_comb begin
    w_rise      = w_s & ~r_prev;
    w_sw        = {N_SRC{bus.sw_we}} & bus.sw_set;
    w_toggle    = bus.cfg_edge ^ r_cfg_edge;
    w_pend_edge = w_rise | w_sw | (r_pend & ~bus.int_fin);
    w_pend_lvl  = w_s | w_sw;
    w_pend_nxt  = ~w_toggle & ((bus.cfg_edge & w_pend_edge) |
                               (~bus.cfg_edge & w_pend_lvl));
    w_ovr_set   = bus.cfg_edge & w_rise & r_pend & ~bus.int_fin;
    w_ovr_nxt   = ~w_toggle & (w_ovr_set | (r_ovr & ~bus.ovr_clr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev     <= '0;
      r_pend     <= '0;
      r_ovr      <= '0;
      r_cfg_edge <= '0;
    end else begin
      r_prev     <= w_s;
      r_pend     <= w_pend_nxt;
      r_ovr      <= w_ovr_nxt;
      r_cfg_edge <= bus.cfg_edge;
    end
  end

  assign bus.int_req = r_pend;
  assign bus.overrun = r_ovr;

endmodule

// File: tb/tb_interrupt_request_capture.sv
// Scoreboard bench: expectations are queued with a due cycle when stimulus is driven.
module tb_interrupt_request_capture;
  import irq_pkg::*;

  localparam int N = 32;

  typedef struct {
    string        tag;
    int           due;
    logic [N-1:0] mask;
    logic [N-1:0] req;
    logic [N-1:0] ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  logic [N-1:0] m0, m3, m5, m7, m12, m20;

  interrupt_request_capture_if #(.N_SRC(N)) bus ();

  interrupt_request_capture #(
    .N_SRC       (N),
    .SYNC_STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  task automatic exp_at(input string tag, input int dly, input logic [N-1:0] mask,
                        input logic [N-1:0] req, input logic [N-1:0] ovr);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + dly;
    e.mask = mask;
    e.req  = req;
    e.ovr  = ovr;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 64) begin
      tick(1);
      guard++;
    end
    check_eq("sb_drain", N'(sb_q.size()), '0);
  endtask

  always @(negedge clk) begin : mon
    exp_t keep[$];
    keep = {};
    foreach (sb_q[k]) begin
      if (sb_q[k].due <= cyc) begin
        check_eq({sb_q[k].tag, ".req"}, bus.int_req & sb_q[k].mask, sb_q[k].req);
        check_eq({sb_q[k].tag, ".ovr"}, bus.overrun & sb_q[k].mask, sb_q[k].ovr);
      end else begin
        keep.push_back(sb_q[k]);
      end
    end
    sb_q = keep;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    m0  = src_onehot(src_idx_t'(0));
    m3  = src_onehot(src_idx_t'(3));
    m5  = src_onehot(src_idx_t'(5));
    m7  = src_onehot(src_idx_t'(7));
    m12 = src_onehot(src_idx_t'(12));
    m20 = src_onehot(src_idx_t'(20));

    rst_n        = 1'b0;
    bus.irq_in   = m5;
    bus.cfg_edge = ~m12;
    bus.int_fin  = '0;
    bus.sw_we    = 1'b0;
    bus.sw_set   = '0;
    bus.ovr_clr  = '0;
    tick(3);
    check_eq("rst_req", bus.int_req, '0);
    check_eq("rst_ovr", bus.overrun, '0);

    // bit 5 high across reset release: one event, no replay after fin
    rst_n = 1'b1;
    exp_at("b5_lat2", 2, m5, '0, '0);
    exp_at("b5_lat3", 3, m5, m5, '0);
    tick(5);
    bus.int_fin = m5;
    exp_at("b5_fin", 1, m5, '0, '0);
    exp_at("b5_no_replay", 6, m5, '0, '0);
    tick(1);
    bus.int_fin = '0;
    drain();

    // bit 3 edge latency and fin
    bus.irq_in[3] = 1'b1;
    exp_at("b3_lat2", 2, m3, '0, '0);
    exp_at("b3_lat3", 3, m3, m3, '0);
    tick(5);
    bus.int_fin = m3;
    exp_at("b3_fin", 1, m3, '0, '0);
    exp_at("b3_stay_low", 3, m3, '0, '0);
    tick(1);
    bus.int_fin = '0;
    drain();

    // bit 7 overrun and clear
    bus.irq_in[7] = 1'b1;
    exp_at("b7_req", 3, m7, m7, '0);
    tick(4);
    bus.irq_in[7] = 1'b0;
    tick(3);
    bus.irq_in[7] = 1'b1;
    exp_at("b7_ovr_pre", 2, m7, m7, '0);
    exp_at("b7_ovr_set", 3, m7, m7, m7);
    tick(5);
    bus.ovr_clr = m7;
    exp_at("b7_ovr_clr", 1, m7, m7, '0);
    tick(1);
    bus.ovr_clr = '0;
    bus.int_fin = m7;
    exp_at("b7_done", 1, m7, '0, '0);
    tick(1);
    bus.int_fin = '0;
    drain();
    bus.irq_in[7] = 1'b0;

    // bit 0 rise coincides with fin
    bus.irq_in[0] = 1'b1;
    exp_at("b0_req", 3, m0, m0, '0);
    tick(4);
    bus.irq_in[0] = 1'b0;
    tick(3);
    bus.irq_in[0] = 1'b1;
    tick(2);
    bus.int_fin = m0;
    exp_at("b0_same_cyc", 1, m0, m0, '0);
    exp_at("b0_hold", 2, m0, m0, '0);
    tick(1);
    bus.int_fin = '0;
    tick(2);
    bus.int_fin = m0;
    exp_at("b0_done", 1, m0, '0, '0);
    tick(1);
    bus.int_fin = '0;
    drain();
    bus.irq_in[0] = 1'b0;

    // bit 12 level mode
    bus.irq_in[12] = 1'b1;
    exp_at("b12_lat2", 2, m12, '0, '0);
    exp_at("b12_lat3", 3, m12, m12, '0);
    tick(5);
    bus.int_fin = m12;
    exp_at("b12_fin_ign", 1, m12, m12, '0);
    tick(1);
    bus.int_fin = '0;
    tick(2);
    bus.irq_in[12] = 1'b0;
    exp_at("b12_fall2", 2, m12, m12, '0);
    exp_at("b12_fall3", 3, m12, '0, '0);
    drain();

    // bit 20 mode toggle clears pend/overrun, no spurious edge on return
    bus.irq_in[20] = 1'b1;
    tick(4);
    bus.irq_in[20] = 1'b0;
    tick(3);
    bus.irq_in[20] = 1'b1;
    exp_at("b20_ovr", 3, m20, m20, m20);
    tick(4);
    bus.cfg_edge[20] = 1'b0;
    exp_at("b20_tog_clr", 1, m20, '0, '0);
    exp_at("b20_lvl", 2, m20, m20, '0);
    tick(3);
    bus.cfg_edge[20] = 1'b1;
    exp_at("b20_back_clr", 1, m20, '0, '0);
    exp_at("b20_no_spur", 4, m20, '0, '0);
    drain();
    bus.irq_in[20] = 1'b0;
    tick(3);

    // software set of two bits, overrun on 31, then mid-run reset
    bus.sw_we  = 1'b1;
    bus.sw_set = 32'h8000_0001;
    exp_at("sw_set", 1, '1, 32'h8000_0001, '0);
    tick(1);
    bus.sw_we      = 1'b0;
    bus.sw_set     = '0;
    bus.irq_in[31] = 1'b1;
    exp_at("b31_ovr", 3, '1, 32'h8000_0001, 32'h8000_0000);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req", bus.int_req, '0);
    check_eq("rst_mid_ovr", bus.overrun, '0);
    bus.irq_in = '0;
    tick(2);
    rst_n = 1'b1;
    exp_at("post_rst", 4, '1, '0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interrupt_request_capture.md
INTERRUPT_REQUEST_CAPTURE -- requirements
Module: interrupt_request_capture

Interface
REQ-001 Parameter N_SRC, default 32, number of interrupt sources; equals int_req width of the downstream interrupt controller.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth per source, legal range 2..3.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 irq_in  in  N_SRC  raw peripheral interrupt lines, asynchronous to clk.
REQ-006 cfg_edge  in  N_SRC  per-source mode: 1 = rising-edge, 0 = level.
REQ-007 int_fin  in  N_SRC  one-hot completion pulse from the interrupt controller.
REQ-008 sw_we  in  1  software pending-write strobe.
REQ-009 sw_set  in  N_SRC  bits to force pending when sw_we = 1.
REQ-010 ovr_clr  in  N_SRC  write-1-to-clear for overrun flags.
REQ-011 int_req  out  N_SRC  registered pending vector to the interrupt controller.
REQ-012 overrun  out  N_SRC  sticky flag per source: edge lost while already pending.

Function
REQ-013 Each irq_in bit shall pass through SYNC_STAGES flops; the last stage is s[i].
REQ-014 A prev[i] flop shall hold s[i] delayed one cycle; rise[i] = s[i] & ~prev[i].
REQ-015 Edge mode: pend[i] set on rise[i] or (sw_we & sw_set[i]); cleared on int_fin[i]; if set and clear occur in the same cycle, pend[i] stays 1.
REQ-016 Level mode: pend[i] next = s[i] | (sw_we & sw_set[i]); int_fin[i] has no effect; the source clears its own line.
REQ-017 int_req shall be the pend register directly, with no combinational path from any input to int_req.
REQ-018 Latency, irq_in rise to int_req = 1, shall be SYNC_STAGES+1 cycles in both modes (3 for the default).
REQ-019 Latency, int_fin[i] to int_req[i] = 0 in edge mode, shall be 1 cycle.
REQ-020 overrun[i] shall set when rise[i] occurs with pend[i] = 1 and int_fin[i] = 0, edge mode only.
REQ-021 overrun[i] shall clear on ovr_clr[i]; a simultaneous set wins.
REQ-022 A toggle of cfg_edge[i] (detected against a registered copy) shall clear pend[i] and overrun[i] in the following cycle; prev[i] keeps tracking, so no spurious edge results.
REQ-023 All N_SRC bits shall be independent; multiple bits may change state in one cycle.
REQ-024 A source held high across reset release in edge mode shall produce exactly one rise and one pending event.
REQ-025 int_fin bits for sources with int_req = 0 shall be ignored without error.

Reset
REQ-026 rst_n = 0 shall asynchronously clear synchronizer stages, prev, pend, overrun and the cfg_edge copy; int_req and overrun read 0.
REQ-027 Reset assertion mid-operation shall discard all pending and overrun state; no event is replayed except per REQ-024.
REQ-028 Reset deassertion shall be synchronized to clk by the SoC; this block applies no internal deassertion synchronizer.

Structure
REQ-029 Shared package irq_pkg shall hold N_SRC, SYNC_STAGES defaults and the source-index type shared with the interrupt controller.
REQ-030 One sub-module irq_sync_bit (SYNC_STAGES-deep single-bit synchronizer, async active-low reset) shall be instantiated per source in a generate loop.
REQ-031 The edge, pending and overrun logic shall reside in the top module as per-bit vector logic.

Verification
REQ-032 Edge mode, bit 3: irq_in[3] 0->1 at cycle 0 -> int_req[3] = 1 at cycle 3; int_fin[3] pulse at cycle 5 -> int_req[3] = 0 at cycle 6.
REQ-033 Edge mode, bit 7: second rise while pending, no fin -> overrun[7] = 1; ovr_clr[7] -> overrun[7] = 0 next cycle; int_req[7] stays 1 throughout.
REQ-034 Edge mode, bit 0: rise and int_fin[0] land in the same cycle -> int_req[0] remains 1 and overrun[0] remains 0.
REQ-035 Level mode, bit 12: irq_in[12] held high and int_fin[12] pulsed -> int_req[12] stays 1; irq_in[12] low -> int_req[12] = 0 after 3 cycles.
REQ-036 sw_we = 1 with sw_set = 0x8000_0001 -> int_req = 0x8000_0001 next cycle; rst_n pulsed low mid-test -> int_req = 0 and overrun = 0 immediately.
REQ-037 irq_in[5] high before and during reset release in edge mode -> exactly one int_req[5] assertion, and none again after int_fin[5].
